serdes_tx_framer: RTL and testbench

Parametrised SERDES transmit framer for the dsp_clk domain. It buffers 16-bit payload words in an internal FIFO and emits them to the SERDES only as whole samples of SAMPLE_WORDS words. It inserts K28.0 idle when no complete sample is available. It periodically, or on request, sends a sample-aligned comma/sync burst so the receiver can regain word and sample alignment. It adds remote flow control (pause) and a FIFO occupancy report.

---
 rtl/serdes_tx_framer.sv | 161 ++++++++++++++++
 tb/tb_serdes_tx_framer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serdes_tx_framer.sv
// SERDES transmit framer: buffers payload words in a FIFO, releases them only
// as whole samples, fills gaps with K28.0 idle and inserts sample-aligned
// K28.1/K28.4 comma/sync bursts periodically or on request.
module serdes_tx_framer #(
  parameter int FIFO_DEPTH     = 16,
  parameter int CNTR_WIDTH     = 4,
  parameter int SAMPLE_WORDS   = 2,
  parameter int ALIGN_INTERVAL = 65535
) (
  input  logic                  dsp_clk,
  input  logic                  dsp_rst,
  input  logic [15:0]           tx_dat_i,
  input  logic                  tx_en,
  output logic                  tx_rdy,
  input  logic                  tx_pause,
  input  logic                  align_req,
  output logic                  ser_tx_clk,
  output logic [15:0]           ser_t,
  output logic                  ser_tklsb,
  output logic                  ser_tkmsb,
  output logic [CNTR_WIDTH:0]   fifo_level,
  output logic                  align_active
);

  localparam int LW  = CNTR_WIDTH + 1;
  localparam int WPW = (SAMPLE_WORDS > 1) ? $clog2(SAMPLE_WORDS) : 1;
  localparam int CDW = $clog2(ALIGN_INTERVAL + 1);

  localparam logic [15:0]    K_IDLE  = 16'h1C1C;
  localparam logic [15:0]    K_COMMA = 16'h3C3C;
  localparam logic [15:0]    K_SYNC  = 16'h9C9C;
  localparam logic [LW-1:0]  LVL_FULL   = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0]  LVL_SAMPLE = LW'(SAMPLE_WORDS);
  localparam logic [WPW-1:0] WP_LAST    = WPW'(SAMPLE_WORDS - 1);
  localparam logic [CDW-1:0] CD_RELOAD  = CDW'(ALIGN_INTERVAL);

  typedef enum logic [1:0] {
    ST_DATA  = 2'd0,
    ST_COMMA = 2'd1,
    ST_SYNC  = 2'd2
  } state_e;

  logic [15:0]           mem [FIFO_DEPTH];
  logic [CNTR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]         level_q;
  logic                  enq, deq;

  state_e         state_q, state_d;
  logic [WPW-1:0] wp_q, wp_d, wp_next;
  logic [CDW-1:0] cd_q, cd_d;
  logic           latch_q, latch_d;
  logic [15:0]    ser_q, ser_d;
  logic [1:0]     k_q, k_d;
  logic           aa_q;
  logic           pending;

  // Ready is gated by reset so no write slips in while the FIFO is being cleared.
  assign tx_rdy     = ~dsp_rst & (level_q != LVL_FULL);
  assign enq        = tx_en & tx_rdy;
  assign fifo_level = level_q;
  assign ser_tx_clk = dsp_clk;
  assign ser_t      = ser_q;
  assign ser_tklsb  = k_q[0];
  assign ser_tkmsb  = k_q[1];
  assign align_active = aa_q;

  // FIFO storage; write-only port, contents need no reset.
  always_ff @(posedge dsp_clk) begin
    if (enq) mem[wr_ptr_q] <= tx_dat_i;
  end

  // FIFO pointers and occupancy; full refuses writes even when a read happens.
  always_ff @(posedge dsp_clk) begin
    if (dsp_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({enq, deq})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign pending = (cd_q == '0) | latch_q;
  assign wp_next = (wp_q == WP_LAST) ? '0 : wp_q + WPW'(1);

  // Framing decision: pick the word for next cycle's wire and the next state.
  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    cd_d    = cd_q;
    latch_d = latch_q | align_req;
    deq     = 1'b0;
    ser_d   = K_IDLE;
    k_d     = 2'b11;
    case (state_q)
      ST_DATA: begin
        cd_d = (cd_q == '0) ? '0 : cd_q - CDW'(1);
        if (wp_q != '0) begin
          // Mid-sample: the rest of the sample is already in the FIFO.
          deq   = 1'b1;
          ser_d = mem[rd_ptr_q];
          k_d   = 2'b00;
          wp_d  = wp_next;
        end else if (pending) begin
          state_d = ST_COMMA;
          latch_d = align_req;
        end else if ((level_q >= LVL_SAMPLE) && !tx_pause) begin
          deq   = 1'b1;
          ser_d = mem[rd_ptr_q];
          k_d   = 2'b00;
          wp_d  = wp_next;
        end
      end
      ST_COMMA: begin
        ser_d = K_COMMA;
        wp_d  = wp_next;
        if (wp_q == WP_LAST) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        ser_d = K_SYNC;
        wp_d  = wp_next;
        if (wp_q == WP_LAST) begin
          state_d = ST_DATA;
          cd_d    = CD_RELOAD;
        end
      end
      default: begin
        state_d = ST_DATA;
        wp_d    = '0;
      end
    endcase
  end

  // State and registered wire outputs; align_active lines up with the burst on the wire.
  always_ff @(posedge dsp_clk) begin
    if (dsp_rst) begin
      state_q <= ST_DATA;
      wp_q    <= '0;
      cd_q    <= CD_RELOAD;
      latch_q <= 1'b0;
      ser_q   <= K_IDLE;
      k_q     <= 2'b11;
      aa_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      cd_q    <= cd_d;
      latch_q <= latch_d;
      ser_q   <= ser_d;
      k_q     <= k_d;
      aa_q    <= (state_q == ST_COMMA) || (state_q == ST_SYNC);
    end
  end

endmodule

// File: tb/tb_serdes_tx_framer.sv
// Bench for serdes_tx_framer: directed vector table, hand sequences for
// fill/pause, align requests and reset mid-burst, then random traffic, all
// shadowed by a queue-based reference model checked every cycle.
module tb_serdes_tx_framer;

  localparam int DEPTH = 16;
  localparam int SW    = 2;
  localparam int AI    = 8;

  logic        dsp_clk = 1'b0;
  logic        dsp_rst = 1'b1;
  logic [15:0] tx_dat_i = '0;
  logic        tx_en = 1'b0;
  logic        tx_rdy;
  logic        tx_pause = 1'b0;
  logic        align_req = 1'b0;
  logic        ser_tx_clk;
  logic [15:0] ser_t;
  logic        ser_tklsb, ser_tkmsb;
  logic [4:0]  fifo_level;
  logic        align_active;

  serdes_tx_framer #(
    .FIFO_DEPTH(DEPTH), .CNTR_WIDTH(4), .SAMPLE_WORDS(SW), .ALIGN_INTERVAL(AI)
  ) dut (
    .dsp_clk(dsp_clk), .dsp_rst(dsp_rst), .tx_dat_i(tx_dat_i), .tx_en(tx_en),
    .tx_rdy(tx_rdy), .tx_pause(tx_pause), .align_req(align_req),
    .ser_tx_clk(ser_tx_clk), .ser_t(ser_t), .ser_tklsb(ser_tklsb),
    .ser_tkmsb(ser_tkmsb), .fifo_level(fifo_level), .align_active(align_active)
  );

  always #5 dsp_clk = ~dsp_clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge dsp_clk);
    #1;
  endtask

  // Reference model: FIFO as a queue, a burst as a count of K words still to
  // send, a sample as a count of data words still owed to the wire.
  logic [15:0] m_q[$];
  logic [15:0] m_ser = 16'h1C1C;
  logic [1:0]  m_k = 2'b11;
  logic        m_aa = 1'b0;
  int          m_lvl = 0;
  int          burst_left = 0;
  int          sample_left = 0;
  int          timer = AI;
  bit          req = 1'b0;

  always @(posedge dsp_clk) begin
    bit rdy, in_data, enter;
    if (dsp_rst) begin
      m_q.delete();
      burst_left = 0; sample_left = 0; timer = AI; req = 1'b0;
      m_ser = 16'h1C1C; m_k = 2'b11; m_aa = 1'b0;
    end else begin
      rdy     = (m_q.size() < DEPTH);
      in_data = (burst_left == 0);
      enter   = 1'b0;
      m_aa    = !in_data;
      m_ser   = 16'h1C1C;
      m_k     = 2'b11;
      if (!in_data) begin
        m_ser = (burst_left > SW) ? 16'h3C3C : 16'h9C9C;
        burst_left--;
        if (burst_left == 0) timer = AI + 1;
      end else if (sample_left > 0) begin
        m_ser = m_q.pop_front(); m_k = 2'b00;
        sample_left--;
      end else if (timer == 0 || req) begin
        enter = 1'b1;
        burst_left = 2 * SW;
      end else if (m_q.size() >= SW && !tx_pause) begin
        m_ser = m_q.pop_front(); m_k = 2'b00;
        sample_left = SW - 1;
      end
      if (in_data || burst_left == 0) timer = (timer == 0) ? 0 : timer - 1;
      if (enter) req = 1'b0;
      if (align_req) req = 1'b1;
      if (tx_en && rdy) m_q.push_back(tx_dat_i);
    end
    m_lvl = m_q.size();
  end

  always @(negedge dsp_clk) begin
    if (chk_en) begin
      chk("m_ser", ser_t, m_ser);
      chk("m_k", {ser_tkmsb, ser_tklsb}, m_k);
      chk("m_lvl", fifo_level, m_lvl);
      chk("m_aa", align_active, m_aa);
      chk("m_rdy", tx_rdy, (!dsp_rst && m_lvl < DEPTH));
    end
  end

  typedef struct {
    logic        en;
    logic [15:0] dat;
    logic [15:0] e_ser;
    logic [1:0]  e_k;
    logic [4:0]  e_lvl;
    logic        e_aa;
  } vec_t;

  function automatic vec_t mkv(logic en, logic [15:0] dat, logic [15:0] es,
                               logic [1:0] ek, logic [4:0] el, logic ea);
    vec_t v;
    v.en = en; v.dat = dat; v.e_ser = es; v.e_k = ek; v.e_lvl = el; v.e_aa = ea;
    return v;
  endfunction

  vec_t tbl[15];
  logic [15:0] got[$];
  bit found;

  initial begin
    // Two words then a full automatic burst once the 8-cycle countdown expires.
    tbl[0]  = mkv(1'b1, 16'h1111, 16'h1C1C, 2'b11, 5'd0, 1'b0);
    tbl[1]  = mkv(1'b1, 16'h2222, 16'h1C1C, 2'b11, 5'd1, 1'b0);
    tbl[2]  = mkv(1'b0, 16'h0000, 16'h1C1C, 2'b11, 5'd2, 1'b0);
    tbl[3]  = mkv(1'b0, 16'h0000, 16'h1111, 2'b00, 5'd1, 1'b0);
    tbl[4]  = mkv(1'b0, 16'h0000, 16'h2222, 2'b00, 5'd0, 1'b0);
    for (int i = 5; i < 10; i++) tbl[i] = mkv(1'b0, 16'h0, 16'h1C1C, 2'b11, 5'd0, 1'b0);
    tbl[10] = mkv(1'b0, 16'h0000, 16'h3C3C, 2'b11, 5'd0, 1'b1);
    tbl[11] = mkv(1'b0, 16'h0000, 16'h3C3C, 2'b11, 5'd0, 1'b1);
    tbl[12] = mkv(1'b0, 16'h0000, 16'h9C9C, 2'b11, 5'd0, 1'b1);
    tbl[13] = mkv(1'b0, 16'h0000, 16'h9C9C, 2'b11, 5'd0, 1'b1);
    tbl[14] = mkv(1'b0, 16'h0000, 16'h1C1C, 2'b11, 5'd0, 1'b0);

    // Reset and its output state.
    dsp_rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_ser", ser_t, 16'h1C1C);
    chk("rst_k", {ser_tkmsb, ser_tklsb}, 2'b11);
    chk("rst_lvl", fifo_level, 0);
    chk("rst_rdy", tx_rdy, 0);
    chk("rst_aa", align_active, 0);
    dsp_rst = 1'b0;

    // Vector table.
    for (int i = 0; i < 15; i++) begin
      tx_en = tbl[i].en; tx_dat_i = tbl[i].dat;
      @(negedge dsp_clk);
      chk("tbl_ser", ser_t, tbl[i].e_ser);
      chk("tbl_k", {ser_tkmsb, ser_tklsb}, tbl[i].e_k);
      chk("tbl_lvl", fifo_level, tbl[i].e_lvl);
      chk("tbl_aa", align_active, tbl[i].e_aa);
      chk("tbl_rdy", tx_rdy, 1);
      tick();
    end
    tx_en = 1'b0;

    // Fill under pause: 17 writes, the last must be dropped.
    tx_pause = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tx_en = 1'b1; tx_dat_i = 16'hA000 + 16'(i);
      tick();
    end
    tx_en = 1'b0;
    chk("full_lvl", fifo_level, 16);
    chk("full_rdy", tx_rdy, 0);
    tx_pause = 1'b0;
    got.delete();
    for (int c = 0; c < 80; c++) begin
      tick();
      if (!ser_tklsb && !ser_tkmsb) got.push_back(ser_t);
    end
    chk("drain_cnt", got.size(), 16);
    for (int i = 0; i < 16 && i < got.size(); i++)
      chk("drain_word", got[i], 16'hA000 + 16'(i));

    // Align request during streaming, then again during SYNC.
    for (int c = 0; c < 30; c++) begin
      tx_en = 1'b1; tx_dat_i = 16'hB000 + 16'(c);
      align_req = (c == 5);
      tick();
    end
    tx_en = 1'b0; align_req = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      tick();
      if (ser_t == 16'h9C9C) found = 1'b1;
    end
    chk("sync_seen", found, 1);
    align_req = 1'b1;
    tick();
    align_req = 1'b0;
    for (int c = 0; c < 30; c++) tick();

    // Reset in the middle of a comma burst.
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      tick();
      if (ser_t == 16'h3C3C && align_active) found = 1'b1;
    end
    chk("comma_seen", found, 1);
    dsp_rst = 1'b1;
    tick();
    dsp_rst = 1'b0;
    chk("mid_rst_ser", ser_t, 16'h1C1C);
    chk("mid_rst_k", {ser_tkmsb, ser_tklsb}, 2'b11);
    chk("mid_rst_lvl", fifo_level, 0);
    chk("mid_rst_aa", align_active, 0);
    for (int r = 0; r < 10; r++) begin
      chk("no_early_burst", align_active, 0);
      tick();
    end
    chk("burst_after_interval", align_active, 1);

    // Random traffic: heavy-pause phase first to exercise a full FIFO.
    for (int c = 0; c < 3000; c++) begin
      tx_en     = ($urandom_range(0, 9) < 7);
      tx_dat_i  = 16'($urandom);
      tx_pause  = (c < 1000) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) < 2);
      align_req = ($urandom_range(0, 39) == 0);
      dsp_rst   = ($urandom_range(0, 299) == 0);
      tick();
    end
    tx_en = 1'b0; tx_pause = 1'b0; align_req = 1'b0; dsp_rst = 1'b0;
    repeat (5) tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
